fp_sign_stream: RTL and testbench

Streaming, multi-lane IEEE-754 sign-manipulation unit: the pipelined, parametrised successor to the single-word combinational sign flip. Each accepted beat carries LANES floating-point words and a mode selecting negate, absolute value, negative-absolute or pass-through. Optional NaN protection and per-lane masking are applied. Sits in the vector datapath between operand fetch and the MAC array, with valid/ready on both sides and a transaction counter for performance monitoring.

---
 rtl/fp_sign_stream.sv | 144 ++++++++++++++
 tb/tb_fp_sign_stream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sign_stream.sv
// Streaming multi-lane IEEE-754 sign unit (NEG/ABS/NABS/PASS).
// Two register stages with valid/ready flow control and a handshake counter.
package fp_sign_stream_pkg;

    typedef enum logic [1:0] {
        M_NEG  = 2'b00,
        M_ABS  = 2'b01,
        M_NABS = 2'b10,
        M_PASS = 2'b11
    } mode_e;

    function automatic logic sign_op(
        input mode_e m,
        input logic  s
    );
        logic r;
        r = s;
        unique case (1'b1)
            (m == M_NEG):  r = ~s;
            (m == M_ABS):  r = 1'b0;
            (m == M_NABS): r = 1'b1;
            (m == M_PASS): r = s;
        endcase
        return r;
    endfunction

endpackage

module fp_sign_stream
    import fp_sign_stream_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int NAN_PASS = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in_data,
    input  logic [1:0]                    in_mode,
    input  logic [LANES-1:0]              in_mask,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*(1+EXP_W+MAN_W)-1:0] out_data,
    output logic [LANES-1:0]              out_nan,
    input  logic                          cnt_clr,
    output logic [31:0]                   op_count
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int DW = LANES * W;
    localparam bit NP = (NAN_PASS != 0);

    typedef struct packed {
        logic [DW-1:0]    data;
        mode_e            mode;
        logic [LANES-1:0] mask;
        logic [LANES-1:0] nan;
    } s1_t;

    logic             s1_valid;
    s1_t              s1;
    s1_t              s1_next;
    logic             s2_valid;
    logic             s2_adv;
    logic             s1_load;
    logic             in_fire;
    logic             out_fire;
    logic [LANES-1:0] in_nan;
    logic [DW-1:0]    s2_data;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_adv;
    assign in_ready = !s1_valid || !s2_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign out_fire = s2_valid && out_ready;

    // NaN: exponent all ones with a nonzero mantissa
    always_comb begin
        in_nan = '0;
        for (int i = 0; i < LANES; i++) begin
            in_nan[i] = (&in_data[i*W+MAN_W +: EXP_W])
                      && (|in_data[i*W +: MAN_W]);
        end
    end

    always_comb begin
        s1_next.data = in_data;
        s1_next.mode = mode_e'(in_mode);
        s1_next.mask = in_mask;
        s1_next.nan  = in_nan;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (s1_load) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1 <= s1_next;
            end
        end
    end

    // Only the sign bit of an enabled lane is touched
    always_comb begin
        s2_data = s1.data;
        for (int i = 0; i < LANES; i++) begin
            if (s1.mask[i] && !(NP && s1.nan[i])) begin
                s2_data[i*W+W-1] =
                    sign_op(s1.mode, s1.data[i*W+W-1]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_nan  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s2_data;
                out_nan  <= s1.nan;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (cnt_clr) begin
            op_count <= '0;
        end else if (out_fire) begin
            op_count <= op_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fp_sign_stream.sv
// Directed bench for fp_sign_stream; two instances cover
// NAN_PASS=1 and NAN_PASS=0 driven from the same inputs.
module tb_fp_sign_stream;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [1:0]   in_mode;
    logic [3:0]   in_mask;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_nan;
    logic         cnt_clr;
    logic [31:0]  op_count;

    logic         in_ready0;
    logic         out_valid0;
    logic [127:0] out_data0;
    logic [3:0]   out_nan0;
    logic [31:0]  op_count0;

    int total = 0;
    int bad   = 0;

    fp_sign_stream #(.NAN_PASS(1)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode),
        .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_nan(out_nan),
        .cnt_clr(cnt_clr), .op_count(op_count)
    );

    fp_sign_stream #(.NAN_PASS(0)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_mode(in_mode),
        .in_mask(in_mask),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_nan(out_nan0),
        .cnt_clr(cnt_clr), .op_count(op_count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string        tag,
        input logic [127:0] obs,
        input logic [127:0] exp
    );
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // one beat through an empty pipeline; called at posedge+1
    task automatic beat(
        input string        tag,
        input logic [127:0] d,
        input logic [1:0]   m,
        input logic [3:0]   k,
        input logic [127:0] e1,
        input logic [127:0] e0,
        input logic [3:0]   en
    );
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        in_mask   = k;
        out_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_v0"}, out_valid, 0);
        @(posedge clk);
        #1;
        chk({tag, "_v1"}, out_valid, 1);
        chk({tag, "_d1"}, out_data, e1);
        chk({tag, "_d0"}, out_data0, e0);
        chk({tag, "_nan"}, out_nan, en);
        chk({tag, "_nan0"}, out_nan0, en);
        @(posedge clk);
        #1;
        chk({tag, "_vend"}, out_valid, 0);
    endtask

    function automatic logic [127:0] mk(
        input int k,
        input bit neg
    );
        logic [127:0] r;
        logic [31:0]  w;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            w = 32'h3F000000 | (32'(k & 255) << 8) | 32'(j);
            if (neg) w = w | 32'h80000000;
            r[j*32 +: 32] = w;
        end
        return r;
    endfunction

    logic [127:0] q[$];
    logic [127:0] held;
    logic [127:0] d_ab;
    logic         hold;
    int           sent;
    int           recv;
    int           cyc;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_mode = 2'b00;
        in_mask = 4'h0;
        out_ready = 1'b0;
        cnt_clr = 1'b0;
        #12;
        chk("rst_rdy", in_ready, 1);
        chk("rst_ov", out_valid, 0);
        chk("rst_od", out_data, 0);
        chk("rst_nan", out_nan, 0);
        chk("rst_cnt", op_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        beat("neg",
             128'h3F800000_00000000_C0600000_40600000,
             2'b00, 4'hF,
             128'hBF800000_80000000_40600000_C0600000,
             128'hBF800000_80000000_40600000_C0600000,
             4'h0);

        d_ab = 128'h40000000_80000000_7F800000_C0600000;
        beat("abs", d_ab, 2'b01, 4'hF,
             128'h40000000_00000000_7F800000_40600000,
             128'h40000000_00000000_7F800000_40600000,
             4'h0);
        beat("nabs", d_ab, 2'b10, 4'hF,
             128'hC0000000_80000000_FF800000_C0600000,
             128'hC0000000_80000000_FF800000_C0600000,
             4'h0);
        beat("pass", d_ab, 2'b11, 4'hF, d_ab, d_ab, 4'h0);

        beat("nan",
             128'h7F800000_FF800001_3F800000_7FC00000,
             2'b00, 4'hF,
             128'hFF800000_FF800001_BF800000_7FC00000,
             128'hFF800000_7F800001_BF800000_FFC00000,
             4'h5);

        beat("mask0",
             128'h7F800001_00000000_FFC00000_C0600000,
             2'b01, 4'h0,
             128'h7F800001_00000000_FFC00000_C0600000,
             128'h7F800001_00000000_FFC00000_C0600000,
             4'hA);

        beat("mask5",
             128'h40600000_40600000_40600000_40600000,
             2'b00, 4'h5,
             128'h40600000_C0600000_40600000_C0600000,
             128'h40600000_C0600000_40600000_C0600000,
             4'h0);

        chk("cnt7", op_count, 7);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr", op_count, 0);

        sent = 0;
        recv = 0;
        cyc = 0;
        hold = 1'b0;
        held = '0;
        in_mode = 2'b00;
        in_mask = 4'hF;
        while (recv < 10 && cyc < 200) begin
            if (cyc >= 3 && cyc < 8) out_ready = 1'b0;
            else out_ready = 1'($urandom_range(0, 1));
            in_valid = (sent < 10) && ($urandom_range(0, 3) != 0);
            in_data = mk(sent, 1'b0);
            #1;
            chk("bp_rdy", in_ready,
                ((sent - recv) < 2) || out_ready);
            if (hold) chk("bp_hold", out_data, held);
            hold = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("bp_extra", 1, 0);
                end else begin
                    chk("bp_data", out_data, q.pop_front());
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(mk(sent, 1'b1));
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_recv", recv, 10);
        chk("bp_cnt", op_count, 10);

        in_valid = 1'b1;
        in_data = mk(20, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("hc_v", out_valid, 1);
        chk("hc_cnt", op_count, 10);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("hc_clr", op_count, 0);
        chk("hc_vend", out_valid, 0);

        beat("pre", mk(30, 1'b0), 2'b00, 4'hF,
             mk(30, 1'b1), mk(30, 1'b1), 4'h0);
        chk("pre_cnt", op_count, 1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = mk(31, 1'b0);
        @(posedge clk);
        #1;
        in_data = mk(32, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("full_v", out_valid, 1);
        chk("full_rdy", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_v", out_valid, 0);
        chk("mr_cnt", op_count, 0);
        chk("mr_d", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mr_rdy", in_ready, 1);
        beat("post", mk(40, 1'b0), 2'b00, 4'hF,
             mk(40, 1'b1), mk(40, 1'b1), 4'h0);
        chk("post_cnt", op_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
